fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined core: owns the PC register, issues requests to

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_adder16.sv | 21 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, default halt opcode and the
// IF/ID instruction word loaded on reset.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_ISSUE,
    S_WAIT,
    S_DROP,
    S_HOLD,
    S_HALTED
  } fetch_state_t;

  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;
  localparam logic [15:0] IFID_RESET_WORD     = 16'h0000;

  function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opcode);
    return instr[15:12] == opcode;
  endfunction

endpackage

// File: rtl/pc_adder16.sv
// 16-bit ripple-carry adder built from full-adder cells; the carry out of bit 15 is dropped,
// so the sum wraps modulo 2^16.
module pc_adder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic [15:0] w_carry;

  assign w_carry[0] = 1'b0;

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_fa
    assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    if (gi < 15) begin : g_carry
      assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, IF/ID register.
// Define FETCH_PERF_EN to add saturating fetched/squashed performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter logic [15:0] PC_STEP     = 16'h0002
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [15:0] i_branch_pc,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_imem_valid,
  output logic [15:0] o_ifid_instr,
  output logic [15:0] o_ifid_pc_plus2,
  output logic        o_ifid_valid,
  output logic [15:0] o_pc,
  output logic        o_halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] o_perf_fetched,
  output logic [15:0] o_perf_squashed
`endif
);

  fetch_state_t r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_buf;
  logic [15:0]  r_ifid_instr;
  logic [15:0]  r_ifid_pc_plus2;
  logic         r_ifid_valid;
  logic         r_halted;

  logic [15:0]  w_pc_next;
  logic [15:0]  w_deliver_data;
  logic         w_deliver;
  logic         w_deliver_halt;

  pc_adder16 u_pc_adder (
    .i_a   (r_pc),
    .i_b   (PC_STEP),
    .o_sum (w_pc_next)
  );

  // A word reaches IF/ID either straight from memory (WAIT) or from the holding buffer (HOLD).
  assign w_deliver_data = (r_state == S_HOLD) ? r_buf : i_imem_rdata;
  assign w_deliver      = !i_flush && !i_stall &&
                          (((r_state == S_WAIT) && i_imem_valid) || (r_state == S_HOLD));
  assign w_deliver_halt = is_halt(w_deliver_data, HALT_OPCODE);

  assign o_imem_req      = !i_rst && !i_flush && (r_state == S_ISSUE);
  assign o_imem_addr     = r_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc_plus2 = r_ifid_pc_plus2;
  assign o_ifid_valid    = r_ifid_valid;
  assign o_pc            = r_pc;
  assign o_halted        = r_halted;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_ISSUE;
      r_pc            <= RESET_PC;
      r_buf           <= IFID_RESET_WORD;
      r_ifid_instr    <= IFID_RESET_WORD;
      r_ifid_pc_plus2 <= 16'h0000;
      r_ifid_valid    <= 1'b0;
      r_halted        <= 1'b0;
    end else begin
      // IF/ID: flush beats stall, stall beats delivery, otherwise a bubble.
      if (i_flush) begin
        r_ifid_valid <= 1'b0;
      end else if (!i_stall) begin
        r_ifid_valid <= w_deliver;
        if (w_deliver) begin
          r_ifid_instr    <= w_deliver_data;
          r_ifid_pc_plus2 <= w_pc_next;
        end
      end

      case (r_state)
        S_ISSUE: begin
          if (i_flush) r_pc <= i_branch_pc;
          else         r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_flush) begin
            r_pc    <= i_branch_pc;
            r_state <= i_imem_valid ? S_ISSUE : S_DROP;
          end else if (i_imem_valid && i_stall) begin
            r_buf   <= i_imem_rdata;
            r_state <= S_HOLD;
          end
        end
        S_DROP: begin
          if (i_flush)      r_pc    <= i_branch_pc;
          if (i_imem_valid) r_state <= S_ISSUE;
        end
        S_HOLD: begin
          if (i_flush) begin
            r_buf   <= IFID_RESET_WORD;
            r_pc    <= i_branch_pc;
            r_state <= S_ISSUE;
          end
        end
        S_HALTED: begin
          if (i_flush) begin
            r_halted <= 1'b0;
            r_pc     <= i_branch_pc;
            r_state  <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase

      // Delivery overrides the state-specific next state chosen above.
      if (w_deliver) begin
        r_pc     <= w_pc_next;
        r_state  <= w_deliver_halt ? S_HALTED : S_ISSUE;
        r_halted <= w_deliver_halt;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_squashed;
  logic        w_squash;

  // A flush squashes work when IF/ID is live or a response is still owed to this stage.
  assign w_squash = i_flush && (r_ifid_valid || (r_state == S_WAIT) || (r_state == S_HOLD));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_fetched  <= 16'h0000;
      r_perf_squashed <= 16'h0000;
    end else begin
      if (w_deliver && (r_perf_fetched != 16'hFFFF)) r_perf_fetched  <= r_perf_fetched + 16'h0001;
      if (w_squash && (r_perf_squashed != 16'hFFFF)) r_perf_squashed <= r_perf_squashed + 16'h0001;
    end
  end

  assign o_perf_fetched  = r_perf_fetched;
  assign o_perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable memory model, an architectural
// fetch-order model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branchPc = 16'h0000;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic [15:0] imemRdata = 16'h0000;
  logic        imemValid = 1'b0;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPcPlus2;
  logic        ifidValid;
  logic [15:0] pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perfFetched;
  logic [15:0] perfSquashed;
`endif

  int checks = 0;
  int failures = 0;
  int memLatency = 1;
  logic [15:0] memArr [logic [15:0]];

  fetch_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_branch_pc     (branchPc),
    .o_imem_req      (imemReq),
    .o_imem_addr     (imemAddr),
    .i_imem_rdata    (imemRdata),
    .i_imem_valid    (imemValid),
    .o_ifid_instr    (ifidInstr),
    .o_ifid_pc_plus2 (ifidPcPlus2),
    .o_ifid_valid    (ifidValid),
    .o_pc            (pc),
    .o_halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched  (perfFetched),
    .o_perf_squashed (perfSquashed)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: explicit entries, otherwise a recognisable non-halt pattern of the address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {4'h1, a[11:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory model: requests seen at the falling edge answer memLatency cycles later.
  logic        reqSeen = 1'b0;
  logic [15:0] addrSeen = 16'h0000;
  logic        memPend = 1'b0;
  int          memCnt = 0;
  logic [15:0] memPendAddr = 16'h0000;

  always @(negedge clk) begin
    reqSeen  = imemReq;
    addrSeen = imemAddr;
  end

  always @(posedge clk) begin
    #1;
    imemValid = 1'b0;
    if (rst) begin
      memPend = 1'b0;
    end else begin
      if (reqSeen) begin
        memPend     = 1'b1;
        memCnt      = memLatency;
        memPendAddr = addrSeen;
      end
      if (memPend) begin
        memCnt--;
        if (memCnt == 0) begin
          imemValid = 1'b1;
          imemRdata = memWord(memPendAddr);
          memPend   = 1'b0;
        end
      end
    end
  end

  // Architectural model: the next fetch address is the last delivered PC + 2, or the flush
  // target; each fresh IF/ID word must be the memory word at the last requested address.
  logic [15:0] modelNext = 16'h0000;
  logic [15:0] inflightAddr = 16'h0000;
  logic [15:0] expWord;
  logic [15:0] expPlus2;
  logic [15:0] prevInstr = 16'h0000;
  logic [15:0] prevPcPlus2 = 16'h0000;
  logic        prevValid = 1'b0;
  logic        prevStall = 1'b0;
  logic        prevFlush = 1'b0;
  logic        modelHalted = 1'b0;
  int          modelDelivered = 0;

  always @(negedge clk) begin
    if (rst) begin
      modelNext      = 16'h0000;
      modelHalted    = 1'b0;
      modelDelivered = 0;
      prevStall      = 1'b0;
      prevFlush      = 1'b0;
    end else begin
      if (prevFlush) begin
        checkOutput("ifid_valid_after_flush", {15'd0, ifidValid}, 16'h0000);
      end else if (prevStall) begin
        checkOutput("ifid_instr_held", ifidInstr, prevInstr);
        checkOutput("ifid_pc_plus2_held", ifidPcPlus2, prevPcPlus2);
        checkOutput("ifid_valid_held", {15'd0, ifidValid}, {15'd0, prevValid});
      end else if (ifidValid) begin
        expWord  = memWord(inflightAddr);
        expPlus2 = inflightAddr + 16'd2;
        checkOutput("ifid_instr_vs_mem", ifidInstr, expWord);
        checkOutput("ifid_pc_plus2_vs_req", ifidPcPlus2, expPlus2);
        modelNext = expPlus2;
        modelDelivered++;
        if (expWord[15:12] == 4'hF) modelHalted = 1'b1;
      end
      checkOutput("pc_vs_model", pc, modelNext);
      checkOutput("halted_vs_model", {15'd0, halted}, {15'd0, modelHalted});
      if (imemReq) begin
        checkOutput("imem_addr_vs_model", imemAddr, modelNext);
        checkOutput("single_outstanding", {15'd0, memPend}, 16'h0000);
        checkOutput("no_req_when_halted", {15'd0, modelHalted}, 16'h0000);
        inflightAddr = imemAddr;
      end
      if (flush) begin
        modelNext   = branchPc;
        modelHalted = 1'b0;
      end
    end
    prevStall   = stall;
    prevFlush   = flush;
    prevInstr   = ifidInstr;
    prevPcPlus2 = ifidPcPlus2;
    prevValid   = ifidValid;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic [15:0] target);
    stall    = s;
    flush    = f;
    branchPc = target;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!ifidValid && n < 20);
    if (!ifidValid) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: ifid_valid never rose, got 0, expected 1", name);
    end
  endtask

  initial begin
    memArr[16'h0000] = 16'h1234;
    memArr[16'h0002] = 16'h5678;
    memArr[16'h0082] = 16'hF000;
    memArr[16'hFFFE] = 16'h7777;

    // Reset values
    repeat (3) step();
    checkOutput("rst_ifid_valid", {15'd0, ifidValid}, 16'h0000);
    checkOutput("rst_ifid_instr", ifidInstr, 16'h0000);
    checkOutput("rst_ifid_pc_plus2", ifidPcPlus2, 16'h0000);
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'h0000);
    checkOutput("rst_imem_req", {15'd0, imemReq}, 16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("first_req", {15'd0, imemReq}, 16'h0001);
    checkOutput("first_addr", imemAddr, 16'h0000);

    // Straight-line fetch with 1-cycle memory
    waitValid("fetch0");
    checkOutput("fetch0_instr", ifidInstr, 16'h1234);
    checkOutput("fetch0_pc_plus2", ifidPcPlus2, 16'h0002);
    checkOutput("second_req", {15'd0, imemReq}, 16'h0001);
    checkOutput("second_addr", imemAddr, 16'h0002);
    waitValid("fetch1");
    checkOutput("fetch1_instr", ifidInstr, 16'h5678);
    checkOutput("fetch1_pc_plus2", ifidPcPlus2, 16'h0004);

    // Response arrives during a 3-cycle stall: held in the buffer, IF/ID frozen
    applyStimulus(1'b1, 1'b0, 16'h0000);
    step();
    step();
    checkOutput("stall_instr_a", ifidInstr, 16'h5678);
    checkOutput("stall_req_a", {15'd0, imemReq}, 16'h0000);
    step();
    checkOutput("stall_instr_b", ifidInstr, 16'h5678);
    checkOutput("stall_valid_b", {15'd0, ifidValid}, 16'h0001);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("unstall_instr", ifidInstr, 16'h1004);
    checkOutput("unstall_pc_plus2", ifidPcPlus2, 16'h0006);
    checkOutput("unstall_valid", {15'd0, ifidValid}, 16'h0001);

    // Flush while waiting on a 3-cycle memory: stale word dropped, refetch at 0x0040
    memLatency = 3;
    step();
    applyStimulus(1'b0, 1'b1, 16'h0040);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("flush_wait_valid", {15'd0, ifidValid}, 16'h0000);
    checkOutput("flush_wait_pc", pc, 16'h0040);
    step();
    checkOutput("drop_no_req", {15'd0, imemReq}, 16'h0000);
    step();
    checkOutput("after_drop_req", {15'd0, imemReq}, 16'h0001);
    checkOutput("after_drop_addr", imemAddr, 16'h0040);
    memLatency = 1;
    waitValid("refetch");
    checkOutput("refetch_instr", ifidInstr, 16'h1040);
    checkOutput("refetch_pc_plus2", ifidPcPlus2, 16'h0042);

    // Flush and stall together: flush wins
    applyStimulus(1'b1, 1'b1, 16'h0080);
    step();
    checkOutput("flush_stall_valid", {15'd0, ifidValid}, 16'h0000);
    checkOutput("flush_stall_pc", pc, 16'h0080);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    #1;
    checkOutput("flush_stall_req_addr", imemAddr, 16'h0080);

    // HALT stops fetch until a flush redirects it
    waitValid("pre_halt");
    checkOutput("pre_halt_instr", ifidInstr, 16'h1080);
    waitValid("halt");
    checkOutput("halt_instr", ifidInstr, 16'hF000);
    checkOutput("halt_valid", {15'd0, ifidValid}, 16'h0001);
    checkOutput("halt_halted", {15'd0, halted}, 16'h0001);
    step();
    checkOutput("halted_no_req", {15'd0, imemReq}, 16'h0000);
    checkOutput("halted_bubble", {15'd0, ifidValid}, 16'h0000);
    step();
    checkOutput("halted_pc", pc, 16'h0084);
    applyStimulus(1'b0, 1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("resume_halted", {15'd0, halted}, 16'h0000);
    #1;
    checkOutput("resume_req", {15'd0, imemReq}, 16'h0001);
    checkOutput("resume_addr", imemAddr, 16'h0010);
    waitValid("resume");
    checkOutput("resume_instr", ifidInstr, 16'h1010);
    checkOutput("resume_pc_plus2", ifidPcPlus2, 16'h0012);

    // PC wraps from 0xFFFE to 0x0000
    applyStimulus(1'b0, 1'b1, 16'hFFFE);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    waitValid("wrap");
    checkOutput("wrap_instr", ifidInstr, 16'h7777);
    checkOutput("wrap_pc_plus2", ifidPcPlus2, 16'h0000);
    checkOutput("wrap_pc", pc, 16'h0000);

    step();
    checkOutput("model_delivered", 16'(modelDelivered), 16'd8);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched_vs_model", perfFetched, 16'(modelDelivered));
    checkOutput("perf_fetched", perfFetched, 16'd8);
    checkOutput("perf_squashed", perfSquashed, 16'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
